// File: rtl/uart_sram_loader.sv
// uart_sram_loader: strips newline-terminated header lines from a byte stream,
// packs the payload into SRAM words in the chosen byte order and writes them
// from a start address until a word limit or the top of the address space.
module uart_sram_loader #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 18,
    parameter int HEADER_LINES = 3,
    parameter bit BIG_ENDIAN   = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Initialize,
    input  logic                  Enable,
    input  logic [ADDR_WIDTH-1:0] Start_address,
    input  logic [ADDR_WIDTH:0]   Word_limit,
    input  logic [7:0]            Rx_data,
    input  logic                  Rx_valid,
    output logic                  Rx_ready,
    output logic [ADDR_WIDTH-1:0] SRAM_address,
    output logic [DATA_WIDTH-1:0] SRAM_write_data,
    output logic                  SRAM_we_n,
    output logic                  Busy,
    output logic                  Done,
    output logic [ADDR_WIDTH:0]   Word_count,
    output logic [15:0]           Checksum
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES - 1);
    localparam logic [3:0]       HDR_LINES = 4'(HEADER_LINES);

    typedef enum logic [1:0] {IDLE, STRIP_HEADER, ASSEMBLE, WRITE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   limit_q, limit_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_n_q, we_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [15:0]           csum_q, csum_d;
    logic [3:0]            line_q, line_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic                  clear;
    logic                  accept;
    logic [ADDR_WIDTH:0]   count_inc;
    logic                  terminate;
    logic [IDX_W-1:0]      lane;

    // Reset and Initialize have the same effect, so they share one clear term
    assign clear     = Reset | Initialize;
    assign accept    = Rx_ready & Rx_valid;
    assign count_inc = count_q + (ADDR_WIDTH+1)'(1);
    assign terminate = ((limit_q != '0) && (count_inc == limit_q)) || (&addr_q);
    assign lane      = BIG_ENDIAN ? (LAST_IDX - idx_q) : idx_q;

    // State register
    always_ff @(posedge Clock) begin
        if (clear) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; WRITE always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (Enable) state_d = (HEADER_LINES == 0) ? ASSEMBLE : STRIP_HEADER;
            end
            STRIP_HEADER: begin
                if (accept && (Rx_data == 8'h0A) && ((line_q + 4'd1) == HDR_LINES))
                    state_d = ASSEMBLE;
            end
            ASSEMBLE: begin
                if (accept && (idx_q == LAST_IDX)) state_d = WRITE;
            end
            WRITE: begin
                state_d = terminate ? IDLE : ASSEMBLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte acceptance is only offered while consuming header or payload
    always_comb begin
        Rx_ready = (state_q == STRIP_HEADER) || (state_q == ASSEMBLE);
    end

    // Datapath next values: latch on start, count lines, pack lanes, advance address
    always_comb begin
        addr_d  = addr_q;
        limit_d = limit_q;
        wdata_d = wdata_q;
        we_n_d  = 1'b1;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;
        csum_d  = csum_q;
        line_d  = line_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (Enable) begin
                    addr_d  = Start_address;
                    limit_d = Word_limit;
                    count_d = '0;
                    csum_d  = '0;
                    busy_d  = 1'b1;
                    line_d  = '0;
                    idx_d   = '0;
                end
            end
            STRIP_HEADER: begin
                if (accept && (Rx_data == 8'h0A)) line_d = line_q + 4'd1;
            end
            ASSEMBLE: begin
                if (accept) begin
                    for (int j = 0; j < BYTES; j++) begin
                        if (lane == IDX_W'(j)) wdata_d[8*j +: 8] = Rx_data;
                    end
                    csum_d = csum_q + {8'h00, Rx_data};
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        we_n_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                count_d = count_inc;
                if (terminate) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; clear discards any partially assembled word
    always_ff @(posedge Clock) begin
        if (clear) begin
            addr_q  <= '0;
            limit_q <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            csum_q  <= '0;
            line_q  <= '0;
            idx_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            limit_q <= limit_d;
            wdata_q <= wdata_d;
            we_n_q  <= we_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            csum_q  <= csum_d;
            line_q  <= line_d;
            idx_q   <= idx_d;
        end
    end

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign Busy            = busy_q;
    assign Done            = done_q;
    assign Word_count      = count_q;
    assign Checksum        = csum_q;

endmodule

// File: tb/tb_uart_sram_loader.sv
// Testbench for uart_sram_loader: a default 16-bit big-endian instance with
// a three-line header, plus a 32-bit little-endian headerless instance.
module tb_uart_sram_loader;
    localparam int AW = 18;

    typedef logic [7:0] byte_q_t[$];

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, initialize;
    logic          enable, enable2;
    logic [AW-1:0] start_address, start_address2;
    logic [AW:0]   word_limit, word_limit2;
    logic [7:0]    rx_data, rx_data2;
    logic          rx_valid, rx_valid2;
    logic          rx_ready, rx_ready2;
    logic [AW-1:0] sram_address, sram_address2;
    logic [15:0]   sram_write_data;
    logic [31:0]   sram_write_data2;
    logic          sram_we_n, sram_we_n2;
    logic          busy, busy2, done, done2;
    logic [AW:0]   word_count, word_count2;
    logic [15:0]   checksum, checksum2;

    uart_sram_loader dut (
        .Clock(clock), .Reset(reset), .Initialize(initialize), .Enable(enable),
        .Start_address(start_address), .Word_limit(word_limit),
        .Rx_data(rx_data), .Rx_valid(rx_valid), .Rx_ready(rx_ready),
        .SRAM_address(sram_address), .SRAM_write_data(sram_write_data),
        .SRAM_we_n(sram_we_n), .Busy(busy), .Done(done),
        .Word_count(word_count), .Checksum(checksum)
    );

    uart_sram_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .HEADER_LINES(0), .BIG_ENDIAN(1'b0)) dut2 (
        .Clock(clock), .Reset(reset), .Initialize(initialize), .Enable(enable2),
        .Start_address(start_address2), .Word_limit(word_limit2),
        .Rx_data(rx_data2), .Rx_valid(rx_valid2), .Rx_ready(rx_ready2),
        .SRAM_address(sram_address2), .SRAM_write_data(sram_write_data2),
        .SRAM_we_n(sram_we_n2), .Busy(busy2), .Done(done2),
        .Word_count(word_count2), .Checksum(checksum2)
    );

    int vectors = 0;
    int miscompares = 0;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Upstream byte source: holds a byte valid until accepted, random gaps between bytes
    byte_q_t src_q;
    int      valid_pct = 100;

    initial begin : driver
        bit fire;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge clock);
            fire = rx_valid && rx_ready;
            @(posedge clock);
            #1;
            if (fire && src_q.size() > 0) void'(src_q.pop_front());
            if (!rx_valid || fire)
                rx_valid = (src_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
            if (src_q.size() > 0) rx_data = src_q[0];
        end
    end

    // Write and Done monitors for both instances
    logic [AW-1:0] got_addr[$];
    logic [15:0]   got_data[$];
    logic [AW-1:0] got_addr2[$];
    logic [31:0]   got_data2[$];
    int ready_in_write = 0;
    int we_run = 0;
    int we_long = 0;
    int done_count = 0;
    int done_count2 = 0;

    always @(negedge clock) begin
        if (!sram_we_n) begin
            got_addr.push_back(sram_address);
            got_data.push_back(sram_write_data);
            if (rx_ready) ready_in_write <= ready_in_write + 1;
            we_run <= we_run + 1;
            if (we_run >= 1) we_long <= we_long + 1;
        end else begin
            we_run <= 0;
        end
        if (!sram_we_n2) begin
            got_addr2.push_back(sram_address2);
            got_data2.push_back(sram_write_data2);
        end
        if (done)  done_count  <= done_count + 1;
        if (done2) done_count2 <= done_count2 + 1;
    end

    // Reference model: strip three header lines, pair payload bytes MSB-first,
    // stop at the word limit or the end of the address space
    logic [AW-1:0] exp_addr[$];
    logic [15:0]   exp_data[$];
    logic [15:0]   exp_sum;
    int            exp_left;

    task automatic buildExpected(input byte_q_t stream, input logic [AW-1:0] start, input logic [AW:0] limit);
        int p = 0;
        int nl = 0;
        int space, n, lim;
        exp_addr.delete();
        exp_data.delete();
        exp_sum = 16'h0000;
        while (nl < 3 && p < stream.size()) begin
            if (stream[p] == 8'h0A) nl++;
            p++;
        end
        space = (1 << AW) - int'(start);
        lim   = int'(limit);
        n     = (lim == 0 || lim > space) ? space : lim;
        if (n > (stream.size() - p) / 2) n = (stream.size() - p) / 2;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(start + AW'(i));
            exp_data.push_back({stream[p + 2*i], stream[p + 2*i + 1]});
            exp_sum = exp_sum + 16'(stream[p + 2*i]) + 16'(stream[p + 2*i + 1]);
        end
        exp_left = stream.size() - p - 2*n;
    endtask

    task automatic startLoad(input logic [AW-1:0] start, input logic [AW:0] limit);
        start_address = start;
        word_limit    = limit;
        enable        = 1'b1;
        @(posedge clock);
        #2;
        enable = 1'b0;
    endtask

    // One complete load run on the default instance, checked against the model
    task automatic applyStimulus(input byte_q_t stream, input logic [AW-1:0] start,
                                 input logic [AW:0] limit, input int pct);
        int cyc, d0, n;
        got_addr.delete();
        got_data.delete();
        buildExpected(stream, start, limit);
        valid_pct = pct;
        @(posedge clock);
        #2;
        src_q = stream;
        d0 = done_count;
        startLoad(start, limit);
        checkOutput("busy_on_start", busy, 1);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        checkOutput("done_reached", done, 1);
        checkOutput("word_count", word_count, exp_addr.size());
        checkOutput("checksum", checksum, exp_sum);
        checkOutput("busy_at_done", busy, 0);
        if (exp_addr.size() > 0) checkOutput("final_address", sram_address, exp_addr[exp_addr.size()-1]);
        repeat (3) @(posedge clock);
        #2;
        checkOutput("done_pulses", done_count - d0, 1);
        checkOutput("bytes_pending", src_q.size(), exp_left);
        checkOutput("write_count", got_addr.size(), exp_addr.size());
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            checkOutput("write_addr", got_addr[i], exp_addr[i]);
            checkOutput("write_data", got_data[i], exp_data[i]);
        end
        src_q.delete();
        rx_valid = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_we_n"}, sram_we_n, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_ready"}, rx_ready, 0);
        checkOutput({tag, "_addr"}, sram_address, 0);
        checkOutput({tag, "_wdata"}, sram_write_data, 0);
        checkOutput({tag, "_count"}, word_count, 0);
        checkOutput({tag, "_csum"}, checksum, 0);
    endtask

    function automatic byte_q_t randomHeader();
        byte_q_t h;
        for (int l = 0; l < 3; l++) begin
            int len = $urandom_range(0, 5);
            for (int i = 0; i < len; i++) begin
                logic [7:0] b = 8'($urandom_range(0, 255));
                if (b == 8'h0A) b = 8'h0B;
                h.push_back(b);
            end
            h.push_back(8'h0A);
        end
        return h;
    endfunction

    initial begin : main
        byte_q_t s;
        string   ppm;
        int      cyc, d0, taken, lim;
        logic [7:0]  b2[5];
        logic [31:0] w2;
        logic [15:0] s2;

        reset = 1'b1; initialize = 1'b0;
        enable = 1'b0; enable2 = 1'b0;
        start_address = '0; word_limit = '0;
        start_address2 = '0; word_limit2 = '0;
        rx_data2 = 8'h00; rx_valid2 = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkResetOutputs("reset");
        checkOutput("reset_we_n2", sram_we_n2, 1);
        @(posedge clock);
        #2;
        reset = 1'b0;

        // Directed PPM-style header, two big-endian words
        ppm = "P6\n320 240\n255\n";
        s.delete();
        for (int i = 0; i < ppm.len(); i++) s.push_back(ppm[i]);
        s.push_back(8'h12); s.push_back(8'h34); s.push_back(8'h56); s.push_back(8'h78);
        applyStimulus(s, 18'h0, 19'd2, 100);
        checkOutput("ppm_checksum", checksum, 16'h0114);

        // Random headers and payloads, random Rx_valid gaps
        for (int r = 0; r < 4; r++) begin
            s = randomHeader();
            lim = (r == 0) ? 32 : $urandom_range(1, 32);
            for (int i = 0; i < 2*lim + $urandom_range(0, 3); i++) s.push_back(8'($urandom_range(0, 255)));
            applyStimulus(s, AW'($urandom_range(0, 4000)), (AW+1)'(lim), (r == 1) ? 100 : $urandom_range(20, 100));
        end

        // Top of address space with unlimited word count
        s = randomHeader();
        for (int i = 0; i < 6; i++) s.push_back(8'($urandom_range(0, 255)));
        applyStimulus(s, 18'h3FFFE, 19'd0, 70);

        // Initialize after one payload byte discards the partial word
        got_addr.delete();
        got_data.delete();
        s = randomHeader();
        s.push_back(8'h5A);
        valid_pct = 100;
        @(posedge clock);
        #2;
        src_q = s;
        startLoad(18'h40, 19'd4);
        cyc = 0;
        while (src_q.size() > 0 && cyc < 500) begin
            @(posedge clock);
            #2;
            cyc++;
        end
        checkOutput("init_bytes_consumed", src_q.size(), 0);
        repeat (2) @(posedge clock);
        #2;
        initialize = 1'b1;
        @(posedge clock);
        #2;
        initialize = 1'b0;
        checkResetOutputs("init");
        checkOutput("init_no_write", got_addr.size(), 0);
        rx_valid = 1'b0;
        s = randomHeader();
        for (int i = 0; i < 6; i++) s.push_back(8'($urandom_range(0, 255)));
        applyStimulus(s, 18'h100, 19'd3, 60);

        // Reset landing on the write cycle
        s = randomHeader();
        for (int i = 0; i < 8; i++) s.push_back(8'($urandom_range(0, 255)));
        valid_pct = 100;
        @(posedge clock);
        #2;
        src_q = s;
        d0 = done_count;
        startLoad(18'h20, 19'd4);
        cyc = 0;
        while (sram_we_n && cyc < 500) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        checkOutput("reset_write_seen", sram_we_n, 0);
        reset = 1'b1;
        @(posedge clock);
        #2;
        checkResetOutputs("reset_in_write");
        reset = 1'b0;
        src_q.delete();
        rx_valid = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        checkOutput("reset_no_done", done_count - d0, 0);

        // 32-bit little-endian headerless instance; trailing 0A must stay pending
        b2[0] = 8'h11; b2[1] = 8'h22; b2[2] = 8'h33; b2[3] = 8'h44; b2[4] = 8'h0A;
        w2 = '0;
        s2 = '0;
        for (int k = 0; k < 4; k++) begin
            w2 = w2 | (32'(b2[k]) << (8*k));
            s2 = s2 + 16'(b2[k]);
        end
        got_addr2.delete();
        got_data2.delete();
        d0 = done_count2;
        start_address2 = 18'h155;
        word_limit2    = 19'd1;
        enable2        = 1'b1;
        @(posedge clock);
        #2;
        enable2 = 1'b0;
        taken = 0;
        for (int k = 0; k < 5; k++) begin
            bit took;
            rx_valid2 = 1'b1;
            rx_data2  = b2[k];
            took = 1'b0;
            cyc = 0;
            while (!took && cyc < 20) begin
                @(negedge clock);
                took = rx_ready2;
                @(posedge clock);
                #2;
                cyc++;
            end
            if (took) taken++;
        end
        checkOutput("le_bytes_taken", taken, 4);
        checkOutput("le_ready_after_done", rx_ready2, 0);
        rx_valid2 = 1'b0;
        checkOutput("le_write_count", got_addr2.size(), 1);
        if (got_addr2.size() > 0) begin
            checkOutput("le_write_addr", got_addr2[0], 18'h155);
            checkOutput("le_write_data", got_data2[0], w2);
        end
        checkOutput("le_word_count", word_count2, 1);
        checkOutput("le_checksum", checksum2, s2);
        checkOutput("le_done_pulses", done_count2 - d0, 1);
        checkOutput("le_busy", busy2, 0);

        checkOutput("rx_ready_in_write", ready_in_write, 0);
        checkOutput("we_n_low_multi_cycle", we_long, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
